// File: rtl/vedic_mul_pkg.sv
// ============================================================================
// Module      : vedic_mul_pkg
// Description : Shared state encoding and sizing constants for the
//               sequential Vedic 8x8 multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vedic_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int NIB_W   = 4;
  localparam int PROD_W  = 16;
  localparam int N_STEPS = 4;

  localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

endpackage

`default_nettype wire

// File: rtl/multiply4x4.sv
// ============================================================================
// Module      : multiply4x4
// Description : Combinational 4x4 unsigned Vedic multiplier built from four
//               2x2 crosswise partial products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiply4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  logic [3:0] w_pp_ll;
  logic [3:0] w_pp_hl;
  logic [3:0] w_pp_lh;
  logic [3:0] w_pp_hh;

  assign w_pp_ll = {2'b00, i_a[1:0]} * {2'b00, i_b[1:0]};
  assign w_pp_hl = {2'b00, i_a[3:2]} * {2'b00, i_b[1:0]};
  assign w_pp_lh = {2'b00, i_a[1:0]} * {2'b00, i_b[3:2]};
  assign w_pp_hh = {2'b00, i_a[3:2]} * {2'b00, i_b[3:2]};

  // Vertical term, two crosswise terms at weight 4, top term at weight 16.
  assign o_p = {4'b0000, w_pp_ll}
             + {2'b00, w_pp_hl, 2'b00}
             + {2'b00, w_pp_lh, 2'b00}
             + {w_pp_hh, 4'b0000};

endmodule

`default_nettype wire

// File: rtl/vedic_mul8_seq_ctrl.sv
// ============================================================================
// Module      : vedic_mul8_seq_ctrl
// Description : 8x8 unsigned multiplier that time-shares one 4x4 core over
//               four cycles, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vedic_mul8_seq_ctrl
  import vedic_mul_pkg::*;
#(
  parameter int W_OP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W_OP-1:0]     a,
  input  logic [W_OP-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   product,
  output logic                busy
);

  mul_state_t          r_state;
  mul_state_t          w_state_nxt;
  logic [W_OP-1:0]     r_a_q;
  logic [W_OP-1:0]     r_b_q;
  logic [PROD_W-1:0]   r_acc;
  logic [1:0]          r_k;

  logic                w_accept;
  logic [NIB_W-1:0]    w_core_a;
  logic [NIB_W-1:0]    w_core_b;
  logic [2*NIB_W-1:0]  w_pp;
  logic [3:0]          w_sh;
  logic [PROD_W-1:0]   w_pp_shifted;
  logic [PROD_W-1:0]   w_acc_nxt;

  // Ready is withheld while reset is asserted, even though the state is IDLE.
  assign in_ready = rst_n &&
                    ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept = in_valid && in_ready;

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == MUL);
  assign product   = r_acc;

  always_comb begin
    w_core_a = '0;
    w_core_b = '0;
    w_sh     = 4'd0;
    if (r_state == MUL) begin
      unique case (r_k)
        2'd0: begin
          w_core_a = r_a_q[NIB_W-1:0];
          w_core_b = r_b_q[NIB_W-1:0];
          w_sh     = 4'd0;
        end
        2'd1: begin
          w_core_a = r_a_q[W_OP-1:NIB_W];
          w_core_b = r_b_q[NIB_W-1:0];
          w_sh     = 4'd4;
        end
        2'd2: begin
          w_core_a = r_a_q[NIB_W-1:0];
          w_core_b = r_b_q[W_OP-1:NIB_W];
          w_sh     = 4'd4;
        end
        default: begin
          w_core_a = r_a_q[W_OP-1:NIB_W];
          w_core_b = r_b_q[W_OP-1:NIB_W];
          w_sh     = 4'd8;
        end
      endcase
    end
  end

  multiply4x4 u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_pp)
  );

  // 255*255 fits in 16 bits, so the sum never needs a carry out.
  assign w_pp_shifted = {{(PROD_W-2*NIB_W){1'b0}}, w_pp} << w_sh;
  assign w_acc_nxt    = r_acc + w_pp_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        if (r_k == LAST_STEP) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (w_accept) begin
          w_state_nxt = MUL;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= '0;
      r_b_q <= '0;
      r_acc <= '0;
      r_k   <= 2'd0;
    end else if (w_accept) begin
      r_a_q <= a;
      r_b_q <= b;
      r_acc <= '0;
      r_k   <= 2'd0;
    end else if (r_state == MUL) begin
      r_acc <= w_acc_nxt;
      r_k   <= r_k + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vedic_mul8_seq_ctrl.sv
// ============================================================================
// Module      : tb_vedic_mul8_seq_ctrl
// Description : Directed and randomised self-checking bench for the
//               sequential 8x8 multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vedic_mul8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  vedic_mul8_seq_ctrl #(.W_OP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  localparam int N_RND = 3000;
  logic [7:0]  bb_a   [3] = '{8'h07, 8'h80, 8'h00};
  logic [7:0]  bb_b   [3] = '{8'h09, 8'h02, 8'hFF};
  logic [15:0] bb_exp [3] = '{16'h003F, 16'h0100, 16'h0000};
  logic [15:0] q [$];
  int          acc_cnt;
  int          cyc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;

    // Reset state
    tick(); tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_product",   {16'd0, product},   32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a multiply
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy_low",  {31'd0, busy},      32'd0);
    check("midrst_product",   {16'd0, product},   32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Single operation with exact latency
    out_ready = 1'b1;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("single_ov_early", {31'd0, out_valid}, 32'd0);
    end
    tick();
    check("single_ov",      {31'd0, out_valid}, 32'd1);
    check("single_product", {16'd0, product},   32'h0000FE01);
    tick();
    check("single_idle_ov",    {31'd0, out_valid}, 32'd0);
    check("single_idle_ready", {31'd0, in_ready},  32'd1);
    check("single_idle_busy",  {31'd0, busy},      32'd0);

    // Backpressure, with an ignored request while stalled
    out_ready = 1'b0;
    a = 8'hA5; b = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_ov",       {31'd0, out_valid}, 32'd1);
      check("bp_product",  {16'd0, product},   32'h000026AC);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_release_ov",   {31'd0, out_valid}, 32'd0);
    check("bp_release_busy", {31'd0, busy},      32'd0);

    // Back-to-back stream on 5-cycle spacing
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = bb_a[i]; b = bb_b[i];
      tick();
      a = 8'hEE; b = 8'hDD;
      for (int j = 1; j <= 3; j++) begin
        tick();
        check("b2b_ov_early", {31'd0, out_valid}, 32'd0);
      end
      tick();
      check("b2b_ov",      {31'd0, out_valid}, 32'd1);
      check("b2b_product", {16'd0, product},   {16'd0, bb_exp[i]});
    end
    in_valid = 1'b0;
    tick();
    check("b2b_end_ov", {31'd0, out_valid}, 32'd0);

    // Operand isolation
    a = 8'h10; b = 8'h10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
    end
    check("iso_ov",      {31'd0, out_valid}, 32'd1);
    check("iso_product", {16'd0, product},   32'h00000100);
    tick();

    // Random traffic against an in-order scoreboard
    acc_cnt = 0;
    cyc     = 0;
    while ((acc_cnt < N_RND || q.size() != 0) && cyc < 60000) begin
      in_valid  = (acc_cnt < N_RND) ? 1'($urandom_range(0, 1)) : 1'b0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(16'(a) * 16'(b));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_extra_result", 32'd1, 32'd0);
        else               check("rnd_product", {16'd0, product}, {16'd0, q.pop_front()});
      end
      tick();
      cyc++;
    end
    check("rnd_no_timeout", {31'd0, (cyc < 60000)}, 32'd1);
    check("rnd_accepts",    acc_cnt,                N_RND);
    in_valid = 1'b0;
    tick();
    check("rnd_end_ov", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
